// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    // Program-counter register index; writes aimed here are discarded.
    localparam int REG_PC = 15;

    // Requester identifiers, also the encoding of last_grant.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/regfile_wb_slot.sv
// One-entry write buffer: holds a single valid addr/data pair for one requester.
// Latency: loaded on the accepting edge, visible the cycle after.
// Backpressure: ready is the inverse of the registered valid bit, so it never depends on inputs.
module regfile_wb_slot
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_dat,
    input  logic              clear,
    output logic              slot_vld,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_dat,
    output logic              ready
);

    // Load only happens while empty and clear only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld  <= 1'b0;
            slot_addr <= '0;
            slot_dat  <= '0;
        end else if (load) begin
            slot_vld  <= 1'b1;
            slot_addr <= load_addr;
            slot_dat  <= load_dat;
        end else if (clear) begin
            slot_vld  <= 1'b0;
        end
    end

    assign ready = ~slot_vld;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two write requesters onto a single register-file write port.
// Latency: accept at edge k, WE3 asserted after edge k+1 at the earliest (file written at k+2).
// Backpressure: per-requester one-entry slot; READY drops while the slot is occupied.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic [15:0]       PENDING,
    output logic              DROP_R15
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REG_PC);

    logic              acc0, acc1;
    logic              is_pc0, is_pc1;
    logic              load0, load1;
    logic              drop_nxt;
    logic              slot0_vld, slot1_vld;
    logic [ADDR_W-1:0] slot0_addr, slot1_addr;
    logic [DATA_W-1:0] slot0_dat, slot1_dat;
    logic              gnt0, gnt1, any_gnt, contention;
    logic              last_grant;
    logic [15:0]       pending_c;

    // Handshake: a transfer to R15 is accepted but never enters the slot.
    assign acc0     = REQ0_VALID & REQ0_READY;
    assign acc1     = REQ1_VALID & REQ1_READY;
    assign is_pc0   = (REQ0_ADDR == PC_ADDR);
    assign is_pc1   = (REQ1_ADDR == PC_ADDR);
    assign load0    = acc0 & ~is_pc0;
    assign load1    = acc1 & ~is_pc1;
    assign drop_nxt = (acc0 & is_pc0) | (acc1 & is_pc1);

    regfile_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clk       (CLK),
        .rst_n     (RESETn),
        .load      (load0),
        .load_addr (REQ0_ADDR),
        .load_dat  (REQ0_DATA),
        .clear     (gnt0),
        .slot_vld  (slot0_vld),
        .slot_addr (slot0_addr),
        .slot_dat  (slot0_dat),
        .ready     (REQ0_READY)
    );

    regfile_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clk       (CLK),
        .rst_n     (RESETn),
        .load      (load1),
        .load_addr (REQ1_ADDR),
        .load_dat  (REQ1_DATA),
        .clear     (gnt1),
        .slot_vld  (slot1_vld),
        .slot_addr (slot1_addr),
        .slot_dat  (slot1_dat),
        .ready     (REQ1_READY)
    );

    // Grant: a lone valid slot always wins; on contention the requester that did not win last time goes.
    always_comb begin
        contention = slot0_vld & slot1_vld;
        gnt1       = slot1_vld & (~slot0_vld | (last_grant == REQ_ID0));
        gnt0       = slot0_vld & ~gnt1;
        any_gnt    = gnt0 | gnt1;
    end

    // Round-robin history only advances on contention, so uncontested writes do not disturb fairness.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            last_grant <= REQ_ID1;
        end else if (contention) begin
            last_grant <= gnt1 ? REQ_ID1 : REQ_ID0;
        end
    end

    // Write-port register; address and data hold when nothing is granted.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            WE3      <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            DROP_R15 <= 1'b0;
        end else begin
            WE3      <= any_gnt;
            DROP_R15 <= drop_nxt;
            if (any_gnt) begin
                A3  <= gnt1 ? slot1_addr : slot0_addr;
                WD3 <= gnt1 ? slot1_dat  : slot0_dat;
            end
        end
    end

    // Outstanding-write mask from registered state only; R15 can never be pending.
    always_comb begin
        pending_c = '0;
        for (int r = 0; r < 15; r++) begin
            pending_c[r] = (slot0_vld && (slot0_addr == ADDR_W'(r))) ||
                           (slot1_vld && (slot1_addr == ADDR_W'(r))) ||
                           (WE3       && (A3         == ADDR_W'(r)));
        end
    end

    assign PENDING = pending_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic [AW-1:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
    logic [DW-1:0] REQ0_DATA = '0, REQ1_DATA = '0;
    logic          REQ0_READY, REQ1_READY, WE3, DROP_R15;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [15:0]   PENDING;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .PENDING    (PENDING),
        .DROP_R15   (DROP_R15)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each requester holds at most one write; writes leave one per edge,
    // contention alternates starting with requester 0.
    logic          m_vld[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_dat[2];
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_wd;
    logic          m_drop;

    task automatic m_reset();
        for (int n = 0; n < 2; n++) begin
            m_vld[n] = 1'b0; m_addr[n] = '0; m_dat[n] = '0;
        end
        m_last = 1; m_we = 1'b0; m_a = '0; m_wd = '0; m_drop = 1'b0;
    endtask

    task automatic m_step();
        logic          iv[2];
        logic [AW-1:0] ia[2];
        logic [DW-1:0] id[2];
        logic          acc[2];
        int            g;
        iv[0] = REQ0_VALID; ia[0] = REQ0_ADDR; id[0] = REQ0_DATA;
        iv[1] = REQ1_VALID; ia[1] = REQ1_ADDR; id[1] = REQ1_DATA;
        for (int n = 0; n < 2; n++) acc[n] = iv[n] && !m_vld[n];
        g = -1;
        if (m_vld[0] && m_vld[1]) begin
            g = 1 - m_last;
            m_last = g;
        end else if (m_vld[0]) begin
            g = 0;
        end else if (m_vld[1]) begin
            g = 1;
        end
        m_we = (g >= 0);
        if (g >= 0) begin
            m_a = m_addr[g];
            m_wd = m_dat[g];
            m_vld[g] = 1'b0;
        end
        m_drop = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                if (ia[n] == 4'd15) m_drop = 1'b1;
                else begin
                    m_vld[n] = 1'b1; m_addr[n] = ia[n]; m_dat[n] = id[n];
                end
            end
        end
    endtask

    function automatic logic [15:0] m_pending();
        logic [15:0] p = '0;
        for (int n = 0; n < 2; n++) if (m_vld[n]) p[m_addr[n]] = 1'b1;
        if (m_we) p[m_a] = 1'b1;
        p[15] = 1'b0;
        return p;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RESETn);
            if (!RESETn) m_reset();
            else m_step();
        end
    end

    // ---------------- consumer register file and per-cycle compare ----------------
    logic [DW-1:0] rf[16];
    wr_t           dut_log[$];

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        forever begin
            @(negedge CLK);
            chk("ready0",  64'(REQ0_READY), 64'(!m_vld[0]));
            chk("ready1",  64'(REQ1_READY), 64'(!m_vld[1]));
            chk("we3",     64'(WE3),        64'(m_we));
            chk("a3",      64'(A3),         64'(m_a));
            chk("wd3",     64'(WD3),        64'(m_wd));
            chk("pending", 64'(PENDING),    64'(m_pending()));
            chk("drop",    64'(DROP_R15),   64'(m_drop));
            chk("we3_r15", 64'(WE3 && (A3 == 4'd15)), 64'(0));
            if (WE3) begin
                dut_log.push_back({A3, WD3});
                rf[A3] = WD3;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            REQ0_VALID = v; REQ0_ADDR = a; REQ0_DATA = d;
        end else begin
            REQ1_VALID = v; REQ1_ADDR = a; REQ1_DATA = d;
        end
    endtask

    task automatic idle();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    initial begin
        int   base;
        int   nacc;
        logic rdy;
        logic [DW-1:0] d;

        // reset state
        #12;
        chk("rst_we3",    64'(WE3), 64'(0));
        chk("rst_a3",     64'(A3), 64'(0));
        chk("rst_wd3",    64'(WD3), 64'(0));
        chk("rst_rdy0",   64'(REQ0_READY), 64'(1));
        chk("rst_rdy1",   64'(REQ1_READY), 64'(1));
        chk("rst_pend",   64'(PENDING), 64'(0));
        chk("rst_drop",   64'(DROP_R15), 64'(0));
        RESETn = 1'b1;
        tick();

        // contention after reset: requester 0 first
        set_req(0, 1'b1, 4'd1, 32'hAAAA0001);
        set_req(1, 1'b1, 4'd2, 32'hBBBB0002);
        tick(); idle();
        chk("c1_rdy0", 64'(REQ0_READY), 64'(0));
        chk("c1_rdy1", 64'(REQ1_READY), 64'(0));
        chk("c1_pend", 64'(PENDING), 64'(16'h0006));
        tick();
        chk("c1_we_a", 64'(WE3), 64'(1));
        chk("c1_a_a",  64'(A3), 64'(1));
        chk("c1_d_a",  64'(WD3), 64'(32'hAAAA0001));
        chk("c1_rdy0b", 64'(REQ0_READY), 64'(1));
        tick();
        chk("c1_a_b",  64'(A3), 64'(2));
        chk("c1_d_b",  64'(WD3), 64'(32'hBBBB0002));
        tick();
        chk("c1_idle", 64'(WE3), 64'(0));
        chk("c1_hold", 64'(WD3), 64'(32'hBBBB0002));

        // repeated contention: requester 1 first
        set_req(0, 1'b1, 4'd1, 32'hAAAA0011);
        set_req(1, 1'b1, 4'd2, 32'hBBBB0012);
        tick(); idle();
        tick();
        chk("c2_a_a", 64'(A3), 64'(2));
        chk("c2_d_a", 64'(WD3), 64'(32'hBBBB0012));
        tick();
        chk("c2_a_b", 64'(A3), 64'(1));
        chk("c2_d_b", 64'(WD3), 64'(32'hAAAA0011));
        tick();

        // single write
        set_req(0, 1'b1, 4'd3, 32'h12345678);
        tick(); idle();
        chk("sw_pend_k",  64'(PENDING), 64'(16'h0008));
        chk("sw_we_k",    64'(WE3), 64'(0));
        tick();
        chk("sw_we",      64'(WE3), 64'(1));
        chk("sw_a3",      64'(A3), 64'(3));
        chk("sw_wd3",     64'(WD3), 64'(32'h12345678));
        chk("sw_pend_k1", 64'(PENDING), 64'(16'h0008));
        tick();
        chk("sw_we_off",  64'(WE3), 64'(0));
        chk("sw_pend_k2", 64'(PENDING), 64'(0));
        chk("sw_rf3",     64'(rf[3]), 64'(32'h12345678));

        // R15 drop
        set_req(1, 1'b1, 4'd15, 32'hDEADBEEF);
        tick(); idle();
        chk("pc_rdy1",  64'(REQ1_READY), 64'(1));
        chk("pc_drop",  64'(DROP_R15), 64'(1));
        chk("pc_we",    64'(WE3), 64'(0));
        chk("pc_pend",  64'(PENDING), 64'(0));
        tick();
        chk("pc_drop_end", 64'(DROP_R15), 64'(0));
        chk("pc_we2",   64'(WE3), 64'(0));
        chk("pc_rf15",  64'(rf[15]), 64'(0));

        // both requesters drop on the same edge: one pulse
        set_req(0, 1'b1, 4'd15, 32'h1);
        set_req(1, 1'b1, 4'd15, 32'h2);
        tick(); idle();
        chk("pc2_drop", 64'(DROP_R15), 64'(1));
        tick();
        chk("pc2_drop_end", 64'(DROP_R15), 64'(0));

        // same target from both: two writes, later grant survives
        base = dut_log.size();
        set_req(0, 1'b1, 4'd5, 32'h1);
        set_req(1, 1'b1, 4'd5, 32'h2);
        tick(); idle();
        tick(); tick(); tick();
        chk("st_count", 64'(dut_log.size() - base), 64'(2));
        if (dut_log.size() - base == 2) begin
            chk("st_a0", 64'(dut_log[base].a), 64'(5));
            chk("st_d0", 64'(dut_log[base].d), 64'(1));
            chk("st_a1", 64'(dut_log[base+1].a), 64'(5));
            chk("st_d1", 64'(dut_log[base+1].d), 64'(2));
        end
        chk("st_rf5", 64'(rf[5]), 64'(2));

        // backpressure: held valid, READY alternates, each value written once in order
        base = dut_log.size();
        d = 32'h100;
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(0, 1'b1, 4'd7, d);
            chk("bp_rdy", 64'(REQ0_READY), 64'((i % 2) == 0));
            rdy = REQ0_READY;
            tick();
            if (rdy) begin
                d = d + 1;
                nacc++;
            end
        end
        idle();
        tick(); tick(); tick();
        chk("bp_acc",   64'(nacc), 64'(8));
        chk("bp_count", 64'(dut_log.size() - base), 64'(8));
        if (dut_log.size() - base == 8) begin
            for (int j = 0; j < 8; j++) begin
                chk("bp_addr", 64'(dut_log[base+j].a), 64'(7));
                chk("bp_data", 64'(dut_log[base+j].d), 64'(32'h100 + j));
            end
        end

        // reset mid-flight with a slot valid and a write on the port
        set_req(0, 1'b1, 4'd9,  32'h99);
        set_req(1, 1'b1, 4'd10, 32'hA0);
        tick();
        chk("mf_pend", 64'(PENDING), 64'(16'h0600));
        tick();
        chk("mf_we", 64'(WE3), 64'(1));
        #2;
        RESETn = 1'b0;
        #1;
        base = dut_log.size();
        chk("mf_we_clr",   64'(WE3), 64'(0));
        chk("mf_a3_clr",   64'(A3), 64'(0));
        chk("mf_wd3_clr",  64'(WD3), 64'(0));
        chk("mf_pend_clr", 64'(PENDING), 64'(0));
        chk("mf_drop_clr", 64'(DROP_R15), 64'(0));
        chk("mf_rdy0",     64'(REQ0_READY), 64'(1));
        chk("mf_rdy1",     64'(REQ1_READY), 64'(1));
        tick();
        idle();
        #2;
        RESETn = 1'b1;
        #1;
        chk("mf_rel_rdy0", 64'(REQ0_READY), 64'(1));
        chk("mf_rel_rdy1", 64'(REQ1_READY), 64'(1));
        tick(); tick(); tick(); tick();
        chk("mf_nowrite", 64'(dut_log.size() - base), 64'(0));
        chk("mf_rf10",    64'(rf[10]), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, register data width.
REQ-002 Parameter: ADDR_W, default 4, register address width (16 registers).
REQ-003 Port: CLK  input  1  single clock, all state on rising edge.
REQ-004 Port: RESETn  input  1  reset, asynchronous, active-low.
REQ-005 Port: REQ0_VALID / REQ1_VALID  input  1  requester n offers a write.
REQ-006 Port: REQ0_ADDR / REQ1_ADDR  input  ADDR_W  destination register.
REQ-007 Port: REQ0_DATA / REQ1_DATA  input  DATA_W  write data.
REQ-008 Port: REQ0_READY / REQ1_READY  output  1  requester n's slot can accept.
REQ-009 Port: WE3  output  1  register-file write enable, registered.
REQ-010 Port: A3  output  ADDR_W  register-file write address, registered.
REQ-011 Port: WD3  output  DATA_W  register-file write data, registered.
REQ-012 Port: PENDING  output  16  per-register outstanding-write mask.
REQ-013 Port: DROP_R15  output  1  one-cycle pulse: accepted write to R15 discarded.

Function
REQ-014 Each requester owns a one-entry slot; REQn_READY SHALL equal NOT slot_valid[n], with no combinational path from any input.
REQ-015 Handshake: a transfer occurs on an edge where VALID=1 and READY=1; ADDR/DATA are captured on that edge.
REQ-016 Transfer with ADDR=15 SHALL NOT load the slot; DROP_R15 SHALL be 1 for the following cycle only. Both requesters dropping on the same edge produce a single pulse.
REQ-017 Grant: on each edge with ≥1 slot valid, exactly one slot is granted, copied into WE3/A3/WD3 (WE3=1), and cleared.
REQ-018 Only slot n valid -> grant n. Both valid -> grant the requester NOT in last_grant, then set last_grant to the granted requester.
REQ-019 No slot valid on an edge -> WE3=0 next cycle; A3/WD3 hold their previous values.
REQ-020 Latency: accept at edge k -> WE3=1 during cycle k+1..k+2 at the earliest -> register file written at edge k+2. A waiting slot is granted within 2 edges of acceptance.
REQ-021 A slot cleared by grant at edge k SHALL show READY=1 in the cycle after k. Refill at edge k+1 is legal, giving a sustained throughput of 1 write per 2 cycles per requester and 1 per cycle in aggregate.
REQ-022 Same address in both slots: both writes are issued in grant order and never merged; the later grant's data survives.
REQ-023 PENDING[r] = (slot0 valid AND addr0=r) OR (slot1 valid AND addr1=r) OR (WE3 AND A3=r). This is combinational from registered state only. PENDING[15] is always 0.
REQ-024 WE3 SHALL never be 1 with A3=15.

Reset
REQ-025 RESETn=0 asynchronously clears both slot_valid, WE3, and DROP_R15; A3 and WD3 clear to 0; last_grant clears to 1, so requester 0 wins the first contention.
REQ-026 Reset assertion mid-operation discards slot contents and any in-flight WE3. After release, READY=1 on both ports in the first cycle.
REQ-027 Reset deassertion takes effect at the first rising CLK edge after RESETn rises.

Structure
REQ-028 A shared package holds DATA_W, ADDR_W, the constant REG_PC=15, and requester-ID constants REQ_ID0=0 and REQ_ID1=1.
REQ-029 One sub-module, regfile_wb_slot (one-entry valid/addr/data buffer with load, clear, and READY), is instantiated twice. The grant logic and output register live in the top level.

Verification
REQ-030 Single write: REQ0 writes addr 3, data 0x12345678 at edge k -> WE3=1, A3=3, WD3=0x12345678 for exactly one cycle starting after edge k+1; PENDING[3]=1 from k to k+2.
REQ-031 Contention after reset: both requesters valid on the same edge (REQ0 addr 1 data 0xAAAA0001, REQ1 addr 2 data 0xBBBB0002) -> REQ0 is written first, REQ1 on the next cycle. A repeat of the contention grants REQ1 first.
REQ-032 R15 drop: REQ1 requests addr 15, data 0xDEADBEEF -> REQ1_READY stays 1, DROP_R15 pulses one cycle, WE3 stays 0, PENDING stays 0.
REQ-033 Same target: REQ0 writes addr 5 data 0x1 and REQ1 writes addr 5 data 0x2 together -> two WE3 cycles on addr 5 with the later grant's data last; a RegisterFile model reads 0x2.
REQ-034 Backpressure: REQ0 is held valid continuously with incrementing data -> READY toggles 1/0, and every value is written exactly once and in order.
REQ-035 Reset mid-flight: RESETn is pulled low while both slots are valid and WE3=1 -> all outputs clear immediately without waiting for CLK, and no write occurs after release.
